// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving an external 8x10 dual-port RAM.
// Converts push/pop requests into RAM strobes and tracks occupancy.
module dpram_fifo_ctrl #(
   parameter int DATA_WIDTH = 10,
   parameter int ADDR_WIDTH = 3,
   parameter int AF_THRESH  = 6,
   parameter int AE_THRESH  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  fifo_error,
   output logic [DATA_WIDTH-1:0] data_a,
   output logic [ADDR_WIDTH-1:0] addr_wa,
   output logic [ADDR_WIDTH-1:0] addr_ra,
   output logic                  we_a,
   output logic                  re_a,
   input  logic [DATA_WIDTH-1:0] q_a
);

   localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH+1)'(AF_THRESH);
   localparam logic [ADDR_WIDTH:0] AE_LVL = (ADDR_WIDTH+1)'(AE_THRESH);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  push_acc;
   logic                  pop_acc;

   // Flags come only from the registered count.
   assign full         = (count == DEPTH);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_LVL);
   assign almost_empty = (count <= AE_LVL);

   assign push_acc = push & ~full & ~reset;
   assign pop_acc  = pop & ~empty & ~reset;

   assign we_a     = push_acc;
   assign addr_wa  = wr_ptr;
   assign data_a   = data_in;
   assign re_a     = pop_acc;
   assign addr_ra  = rd_ptr;
   assign data_out = q_a;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         valid_out  <= 1'b0;
         fifo_error <= 1'b0;
      end else begin
         if (push_acc)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_acc)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_acc, pop_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         valid_out <= pop_acc;
         if ((push & full) | (pop & empty))
            fifo_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl with an attached RAM model.
// Expectations come from a queue-based FIFO reference.
module tb_dpram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       push = 1'b0;
   logic       pop = 1'b0;
   logic [9:0] data_in = '0;
   logic [9:0] data_out;
   logic       valid_out;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [3:0] count;
   logic       fifo_error;
   logic [9:0] data_a;
   logic [2:0] addr_wa;
   logic [2:0] addr_ra;
   logic       we_a;
   logic       re_a;
   logic [9:0] q_a;

   logic [9:0] mem [8];

   int checks = 0;
   int failures = 0;

   logic [9:0] ref_q [$];
   int         wr_total = 0;
   int         rd_total = 0;
   logic       exp_err = 1'b0;
   logic       exp_valid = 1'b0;
   logic [9:0] exp_data = '0;

   dpram_fifo_ctrl dut (
      .clk(clk), .reset(reset), .push(push), .data_in(data_in),
      .pop(pop), .data_out(data_out), .valid_out(valid_out),
      .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .count(count),
      .fifo_error(fifo_error), .data_a(data_a), .addr_wa(addr_wa),
      .addr_ra(addr_ra), .we_a(we_a), .re_a(re_a), .q_a(q_a)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (we_a) mem[addr_wa] <= data_a;
      if (re_a) q_a <= mem[addr_ra];
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      int n;
      n = ref_q.size();
      chk("count", 32'(count), 32'(n));
      chk("full", 32'(full), 32'(n == 8));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("almost_full", 32'(almost_full), 32'(n >= 6));
      chk("almost_empty", 32'(almost_empty), 32'(n <= 1));
      chk("fifo_error", 32'(fifo_error), 32'(exp_err));
      chk("valid_out", 32'(valid_out), 32'(exp_valid));
      if (exp_valid)
         chk("data_out", 32'(data_out), 32'(exp_data));
   endtask

   task automatic cycle(input logic p, input logic o,
                        input logic [9:0] d, input logic r);
      int  n;
      logic wacc, racc;
      @(negedge clk);
      check_state();
      push = p; pop = o; data_in = d; reset = r;
      #1;
      n = ref_q.size();
      wacc = p && !r && n < 8;
      racc = o && !r && n > 0;
      chk("we_a", 32'(we_a), 32'(wacc));
      chk("re_a", 32'(re_a), 32'(racc));
      if (wacc) begin
         chk("addr_wa", 32'(addr_wa), 32'(wr_total % 8));
         chk("data_a", 32'(data_a), 32'(d));
      end
      if (racc)
         chk("addr_ra", 32'(addr_ra), 32'(rd_total % 8));
      @(posedge clk);
      if (r) begin
         ref_q.delete();
         wr_total = 0;
         rd_total = 0;
         exp_err = 1'b0;
         exp_valid = 1'b0;
      end else begin
         if ((p && n == 8) || (o && n == 0))
            exp_err = 1'b1;
         exp_valid = racc;
         if (racc) begin
            exp_data = ref_q.pop_front();
            rd_total++;
         end
         if (wacc) begin
            ref_q.push_back(d);
            wr_total++;
         end
      end
   endtask

   initial begin
      // 1: reset with requests asserted
      cycle(1, 1, 10'h155, 1);
      cycle(1, 1, 10'h2aa, 1);
      // 2: fill, then overflow
      for (int i = 1; i <= 8; i++)
         cycle(1, 0, 10'(i), 0);
      cycle(1, 0, 10'h3ff, 0);
      // 3: drain
      for (int i = 0; i < 8; i++)
         cycle(0, 1, 10'h0, 0);
      cycle(0, 0, 10'h0, 0);
      // 4: pointer wrap
      cycle(0, 0, 10'h0, 1);
      for (int i = 0; i < 5; i++)
         cycle(1, 0, 10'(10'h100 + i), 0);
      for (int i = 0; i < 5; i++)
         cycle(0, 1, 10'h0, 0);
      for (int i = 0; i < 6; i++)
         cycle(1, 0, 10'(10'h100 + i), 0);
      for (int i = 0; i < 6; i++)
         cycle(0, 1, 10'h0, 0);
      cycle(0, 0, 10'h0, 0);
      // 5: simultaneous push/pop at count 3, then at empty
      cycle(0, 0, 10'h0, 1);
      for (int i = 0; i < 3; i++)
         cycle(1, 0, 10'(10'h200 + i), 0);
      for (int i = 0; i < 4; i++)
         cycle(1, 1, 10'($urandom_range(0, 1023)), 0);
      for (int i = 0; i < 3; i++)
         cycle(0, 1, 10'h0, 0);
      cycle(0, 0, 10'h0, 0);
      cycle(1, 1, 10'h0ab, 0);
      // 6: reset right after a pop
      for (int i = 0; i < 4; i++)
         cycle(1, 0, 10'(10'h300 + i), 0);
      cycle(0, 1, 10'h0, 0);
      cycle(0, 0, 10'h0, 1);
      cycle(1, 0, 10'h077, 0);
      cycle(0, 1, 10'h0, 0);
      // random traffic
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               10'($urandom_range(0, 1023)),
               ($urandom_range(0, 63) == 0));
      cycle(0, 0, 10'h0, 0);
      @(negedge clk);
      check_state();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
